// File: rtl/imm_gen_queue_pkg.sv
// rtl/imm_gen_queue_pkg.sv - shared CPU opcode constants and immediate format codes
package imm_gen_queue_pkg;

    localparam logic [6:0] LType     = 7'b0000011;
    localparam logic [6:0] IType     = 7'b0010011;
    localparam logic [6:0] jalrType  = 7'b1100111;
    localparam logic [6:0] SType     = 7'b0100011;
    localparam logic [6:0] BType     = 7'b1100011;
    localparam logic [6:0] luiType   = 7'b0110111;
    localparam logic [6:0] auipcType = 7'b0010111;
    localparam logic [6:0] jalType   = 7'b1101111;
    localparam logic [6:0] sysType   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_Z   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_t;

endpackage

// File: rtl/imm_gen_queue_imm_decode.sv
// rtl/imm_gen_queue_imm_decode.sv - combinational opcode decode and immediate extension
module imm_decode
    import imm_gen_queue_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit U_SHIFTED = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        unused_funct_bits;

    // funct3[1:0] never influences the immediate
    assign unused_funct_bits = ^inst[13:12];

    // Every format is built as a signed 32-bit value; Z is positive so sign extension doubles as zero extension.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_I;
        illegal = 1'b0;
        case (inst[6:0])
            LType, IType, jalrType: imm32 = {{20{inst[31]}}, inst[31:20]};
            SType: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            BType: begin
                fmt   = FMT_B;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            luiType, auipcType: begin
                fmt   = FMT_U;
                imm32 = U_SHIFTED ? {inst[31:12], 12'b0} : {{12{inst[31]}}, inst[31:12]};
            end
            jalType: begin
                fmt   = FMT_J;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            sysType: begin
                if (inst[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, inst[19:15]};
                end else begin
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            default: begin
                fmt     = FMT_BAD;
                imm32   = '1;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_queue.sv
// rtl/imm_gen_queue.sv - decoded-immediate FIFO between instruction register and operand muxes
module imm_gen_queue
    import imm_gen_queue_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter bit U_SHIFTED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    generate
        if (!(XLEN == 32 || XLEN == 64) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
            $error("imm_gen_queue: XLEN must be 32/64 and DEPTH a power of two >= 2");
        end
    endgenerate

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN      (XLEN),
        .U_SHIFTED (U_SHIFTED)
    ) u_imm_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0] mem_imm [DEPTH];
    logic [2:0]      mem_fmt [DEPTH];
    logic            mem_ill [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // Full blocks a push even when a pop happens in the same cycle: no ready pass-through.
    assign in_ready  = (count != CW'(DEPTH)) && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm     = mem_imm[rd_ptr];
    assign out_fmt     = mem_fmt[rd_ptr];
    assign out_illegal = mem_ill[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_fmt[i] <= FMT_I;
                mem_ill[i] <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr] <= dec_imm;
                mem_fmt[wr_ptr] <= dec_fmt;
                mem_ill[wr_ptr] <= dec_illegal;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_queue.sv
// tb/tb_imm_gen_queue.sv - self-checking bench for imm_gen_queue (XLEN 32/U shifted and XLEN 64/U legacy)
module tb_imm_gen_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        out_ready = 1'b0;

    logic        rdy32, val32, ill32, rdy64, val64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    always #5 clk = ~clk;

    imm_gen_queue #(.XLEN(32), .DEPTH(DEPTH), .U_SHIFTED(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .out_valid(val32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_queue #(.XLEN(64), .DEPTH(DEPTH), .U_SHIFTED(1'b0)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .out_valid(val64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64)
    );

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [2:0]  f;
        logic        il;
    } ent_t;

    ent_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h7f};

    function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endfunction

    // Reference decode from the instruction-set rules, using signed arithmetic on 64-bit integers.
    function automatic ent_t ref_decode(logic [31:0] i);
        ent_t   e;
        longint v;
        longint u0;
        logic   is_u;
        is_u = 1'b0;
        u0   = 0;
        e.il = 1'b0;
        e.f  = 3'd0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: v = longint'($signed(i[31:20]));
            7'h23: begin e.f = 3'd1; v = longint'($signed({i[31:25], i[11:7]})); end
            7'h63: begin e.f = 3'd2; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h37, 7'h17: begin
                e.f  = 3'd3;
                u0   = longint'($signed(i[31:12]));
                v    = u0 * 4096;
                is_u = 1'b1;
            end
            7'h6f: begin e.f = 3'd4; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h73: begin
                if (i[14]) begin e.f = 3'd5; v = longint'(i[19:15]); end
                else v = longint'($signed(i[31:20]));
            end
            default: begin e.f = 3'd7; v = -1; e.il = 1'b1; end
        endcase
        e.i32 = {32'h0, v[31:0]};
        e.i64 = is_u ? u0 : v;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    // One clock: drive inputs after negedge, check against the model, then advance the model at posedge.
    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic fl, input logic rs,
                        output logic accepted);
        logic exp_rdy, exp_val, do_push, do_pop;
        ent_t h;
        @(negedge clk);
        in_valid = v; in_inst = w; out_ready = r; flush = fl; rst = rs;
        #1;
        exp_rdy = (q.size() < DEPTH) && !rs;
        exp_val = (q.size() != 0);
        check("in_ready32", 64'(rdy32), 64'(exp_rdy));
        check("in_ready64", 64'(rdy64), 64'(exp_rdy));
        check("out_valid32", 64'(val32), 64'(exp_val));
        check("out_valid64", 64'(val64), 64'(exp_val));
        if (exp_val) begin
            h = q[0];
            check("imm32", 64'(imm32), h.i32);
            check("imm64", imm64, h.i64);
            check("fmt32", 64'(fmt32), 64'(h.f));
            check("fmt64", 64'(fmt64), 64'(h.f));
            check("ill32", 64'(ill32), 64'(h.il));
            check("ill64", 64'(ill64), 64'(h.il));
        end
        do_push = v && exp_rdy;
        do_pop  = exp_val && r;
        @(posedge clk);
        accepted = do_push && !rs && !fl;
        if (rs || fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(ref_decode(w));
        end
        #1;
    endtask

    task automatic head_is(string tag, logic [63:0] e32, logic [63:0] e64, logic [2:0] f, logic il);
        check({tag, "_v"}, 64'(val32), 64'(1));
        check({tag, "_imm32"}, 64'(imm32), e32);
        check({tag, "_imm64"}, imm64, e64);
        check({tag, "_fmt"}, 64'(fmt32), 64'(f));
        check({tag, "_ill"}, 64'(ill32), 64'(il));
    endtask

    initial begin
        logic acc;
        int   guard;
        logic [31:0] w;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(rdy32), 64'(0));
        check("rst_out_valid", 64'(val32), 64'(0));
        check("rst_imm32", 64'(imm32), 64'(0));
        check("rst_imm64", imm64, 64'(0));
        check("rst_fmt", 64'(fmt32), 64'(0));
        check("rst_ill", 64'(ill64), 64'(0));

        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        step(1'b1, 32'hFFF00093, 1'b1, 1'b0, 1'b0, acc);
        head_is("addi", 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b0);
        step(1'b1, 32'hFE112E23, 1'b1, 1'b0, 1'b0, acc);
        head_is("sw", 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0);
        step(1'b1, 32'hFE000CE3, 1'b1, 1'b0, 1'b0, acc);
        head_is("beq", 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0);
        step(1'b1, 32'h12345037, 1'b1, 1'b0, 1'b0, acc);
        head_is("lui", 64'h12345000, 64'h00012345, 3'd3, 1'b0);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0, acc);
        head_is("bad", 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd7, 1'b1);
        step(1'b1, 32'h000FD073, 1'b1, 1'b0, 1'b0, acc);
        head_is("csrzimm", 64'h1F, 64'h1F, 3'd5, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure: two accepts fill the queue, the third word is held until one pop has happened.
        step(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00200093, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00300093, 1'b0, 1'b0, 1'b0, acc);
        check("third_held", 64'(acc), 64'(0));
        head_is("bp_head", 64'h1, 64'h1, 3'd0, 1'b0);
        step(1'b1, 32'h00300093, 1'b1, 1'b0, 1'b0, acc);
        check("third_blocked_on_pop", 64'(acc), 64'(0));
        step(1'b1, 32'h00300093, 1'b1, 1'b0, 1'b0, acc);
        check("third_accepted", 64'(acc), 64'(1));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Flush with a full queue and a word offered.
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00500093, 1'b1, 1'b1, 1'b0, acc);
        check("flush_valid", 64'(val32), 64'(0));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Reset mid-operation with a full queue.
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00600093, 1'b1, 1'b0, 1'b1, acc);
        check("rst2_valid", 64'(val64), 64'(0));
        check("rst2_imm32", 64'(imm32), 64'(0));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Sustained push and pop every cycle across pointer wrap.
        step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0, acc);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0, acc);
            check("sustain_accept", 64'(acc), 64'(1));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Random traffic with occasional flush.
        guard = 0;
        for (int k = 0; k < 200; k++) begin
            w = rand_inst();
            step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), 1'b0, acc);
            if (acc) guard++;
        end
        check("random_some_accepts", 64'(guard > 20), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_gen_queue.md
Name: imm_gen_queue

Overview:
- Parametrised, buffered immediate generator for the multi-cycle CPU.
- Accepts full 32-bit instruction words, not pre-sliced immediate fields.
- Decodes the format from the opcode, forms the XLEN-wide immediate, and queues results in a small FIFO with valid/ready handshakes on both sides.
- Sits between the instruction register and the ALU-operand/PC-target muxes; lets fetch run ahead of the control FSM.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- U_SHIFTED, 1, U-type result format:
  - 1: {inst[31:12], 12'b0}, sign-extended to XLEN.
  - 0: inst[31:12] right-aligned and sign-extended (legacy form).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous queue clear (branch redirect/trap)
- in_valid  input  1  instruction word offered
- in_ready  output  1  queue can accept
- in_inst  input  32  raw instruction word
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_imm  output  XLEN  extended immediate of head entry
- out_fmt  output  3  head format: I=0, S=1, B=2, U=3, J=4, Z=5, BAD=7
- out_illegal  output  1  head opcode not recognised

Behaviour:
- Reset (clk, rst synchronous active-high):
  - Read and write pointers and count go to 0.
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst is released.
- Opcode decode (inst[6:0]):
  - 0000011, 0010011, 1100111 → I: sign-extend inst[31:20].
  - 0100011 → S: sign-extend {inst[31:25], inst[11:7]}.
  - 1100011 → B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 0110111, 0010111 → U: per U_SHIFTED.
  - 1101111 → J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - 1110011 with inst[14]=1 → Z: zero-extend inst[19:15].
  - 1110011 with inst[14]=0 → I.
  - Any other opcode → BAD: imm all ones, out_illegal=1.
- Push and pop:
  - Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH) && !rst. No combinational pass-through from in_ready to out_ready: a full queue blocks a push even if a pop happens in the same cycle.
  - Latency: a push into an empty queue gives out_valid=1 on the next cycle. The pushed word's decode appears on out_* in that same cycle.
  - Simultaneous push and pop with the queue neither full nor empty: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH; order is strictly FIFO.
- Head stability: out_imm, out_fmt and out_illegal are taken from the stored head entry. They stay stable while out_valid && !out_ready.
- Flush:
  - Clears count and pointers; out_valid=0 on the next cycle.
  - Takes priority over a push or pop in the same cycle; the word offered that cycle is discarded.
- Reset mid-operation behaves exactly like flush, plus the output-register clears listed under Reset.
- Decode is registered at push time: each entry stores the decoded imm, fmt and illegal, not the raw word.
- Invalid parameters (XLEN not 32/64, DEPTH<2 or not a power of two) stop elaboration via a generate-time check.

Decomposition:
- Shared constants go in the existing CPU constant header:
  - Opcode constants (IType, SType, LType, BType, jalType, jalrType, luiType, auipcType, sysType).
  - Format codes FMT_I/S/B/U/J/Z/BAD.
- Sub-module imm_decode: purely combinational, inst in → {imm, fmt, illegal} out, parametrised on XLEN and U_SHIFTED. Instantiated once on the push side.
- The top level holds the FIFO storage, pointers, count and handshake logic.

Test Plan:
- Push 0xFFF00093 (addi -1), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=0. With XLEN=64 → 0xFFFFFFFF_FFFFFFFF.
- Push 0xFE112E23 (sw -4), then 0xFE000CE3 (beq -8) back-to-back → 0xFFFFFFFC fmt=1, then 0xFFFFFFF8 fmt=2, on consecutive cycles.
- Push 0x12345037 (lui) → 0x12345000 fmt=3. With U_SHIFTED=0 → 0x00012345. Push 0x0000007F → 0xFFFFFFFF, fmt=7, out_illegal=1.
- DEPTH=2, out_ready=0, offer 3 words → in_ready drops after 2 accepts and the third is held. Raise out_ready → outputs appear in push order, and the third is accepted on the first pop cycle + 1.
- Queue full, assert flush with in_valid=1 → next cycle out_valid=0, count=0, flushed word not stored. Repeat with rst instead → in_ready=0 during rst, 1 after.
- Sustained push+pop every cycle for 20 words across pointer wrap → no drops or duplicates; scoreboard matches the reference decode.
